// File: rtl/capture_controller.sv
// capture_controller: sequences a 4-channel circular sample RAM for a logic analyzer.
// Arm -> pre-trigger fill -> wait for trigger -> post-trigger fill -> done -> readout
// (oldest sample first) over a valid/ready port.
// Optional feature: define TRIG_EDGE_EN to add the trig_edge port (per-channel edge trigger).
module capture_controller #(
  parameter int ADDR_WIDTH = 13,
  parameter int RAM_ADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            probe,
  input  logic [3:0]            ch_en,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] pre_count,
  input  logic [3:0]            trig_mask,
  input  logic [3:0]            trig_value,
`ifdef TRIG_EDGE_EN
  input  logic [3:0]            trig_edge,
`endif
  input  logic                  rd_start,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [3:0]            rd_data,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [3:0]            ram_we,
  output logic [3:0]            ram_data,
  input  logic [3:0]            ram_q,
  output logic                  busy,
  output logic                  triggered,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] trig_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST = '1;
  localparam logic [ADDR_WIDTH-1:0] ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE, S_READ} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] wr_ptr, fill, post, rd_ptr, rd_cnt, pre_l;
  logic [3:0]            ch_en_l;
  logic                  writing, accept, do_arm, hit;
  logic [3:0]            lvl_ok, ch_ok;
  logic [ADDR_WIDTH-1:0] rd_addr;

  assign writing = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
  assign accept  = rd_valid & rd_ready;
  assign do_arm  = arm && ((state == S_IDLE) || (state == S_DONE));
  assign rd_addr = accept ? rd_ptr + ONE : rd_ptr;

  assign ram_we   = writing ? ch_en_l : 4'b0000;
  assign ram_data = probe;
  assign busy     = writing || (state == S_READ);
  assign done     = (state == S_DONE) || (state == S_READ);
  assign rd_data  = rd_valid ? (ram_q & ch_en_l) : 4'b0000;

  // Per-channel level match; unmasked channels always agree.
  assign lvl_ok = ~(probe ^ trig_value);

`ifdef TRIG_EDGE_EN
  logic [3:0] prev_probe;
  logic       prev_vld;
  logic [3:0] edge_ok;

  // An edge channel needs a transition into the requested level vs. the previous sample.
  assign edge_ok = {4{prev_vld}} & (prev_probe ^ probe) & lvl_ok;
  assign ch_ok   = (trig_edge & edge_ok) | (~trig_edge & lvl_ok);

  // Previous-sample history; invalid until the first write of a capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_probe <= 4'b0000;
      prev_vld   <= 1'b0;
    end else if (do_arm) begin
      prev_vld   <= 1'b0;
    end else if (writing) begin
      prev_probe <= probe;
      prev_vld   <= 1'b1;
    end
  end
`else
  assign ch_ok = lvl_ok;
`endif

  assign hit = &(ch_ok | ~trig_mask);

  // RAM address mux: write pointer while capturing, look-ahead read pointer while reading.
  always_comb begin
    ram_addr = '0;
    if (writing)
      ram_addr[ADDR_WIDTH-1:0] = wr_ptr;
    else if (state == S_READ)
      ram_addr[ADDR_WIDTH-1:0] = rd_addr;
  end

  // Capture/readout sequencer with its pointers, counters and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      fill      <= '0;
      post      <= '0;
      rd_ptr    <= '0;
      rd_cnt    <= '0;
      pre_l     <= '0;
      ch_en_l   <= 4'b0000;
      trig_addr <= '0;
      triggered <= 1'b0;
      rd_valid  <= 1'b0;
    end else if (abort) begin
      state     <= S_IDLE;
      triggered <= 1'b0;
      rd_valid  <= 1'b0;
    end else if (do_arm) begin
      state     <= (pre_count == '0) ? S_WAIT : S_PRE;
      wr_ptr    <= '0;
      fill      <= '0;
      ch_en_l   <= ch_en;
      pre_l     <= pre_count;
      triggered <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      case (state)
        S_PRE: begin
          wr_ptr <= wr_ptr + ONE;
          fill   <= fill + ONE;
          if (fill + ONE == pre_l) state <= S_WAIT;
        end
        S_WAIT: begin
          wr_ptr <= wr_ptr + ONE;
          if (hit) begin
            trig_addr <= wr_ptr;
            triggered <= 1'b1;
            post      <= LAST - pre_l;
            state     <= (pre_l == LAST) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          wr_ptr <= wr_ptr + ONE;
          post   <= post - ONE;
          if (post == ONE) state <= S_DONE;
        end
        S_DONE: begin
          if (rd_start) begin
            state    <= S_READ;
            rd_ptr   <= trig_addr - pre_l;
            rd_cnt   <= '0;
            rd_valid <= 1'b0;
          end
        end
        S_READ: begin
          rd_valid <= 1'b1;
          if (accept) begin
            rd_ptr <= rd_ptr + ONE;
            rd_cnt <= rd_cnt + ONE;
            if (rd_cnt == LAST) begin
              state     <= S_IDLE;
              rd_valid  <= 1'b0;
              triggered <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
